// File: rtl/mac_ctrl_pkg.sv
// Shared types and sizing helpers for the MAC sequencer.
package mac_ctrl_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_ACC_W      = 16;
  localparam int unsigned DEF_N_TAPS     = 4;
  localparam int unsigned DEF_ACC_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    RUN,
    CAPTURE,
    HOLD
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter with a zero flag; decrement saturates at zero.
module mac_seq_cnt
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero_c
);

  assign zero_c = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero_c) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer steering a byte stream into the MAC weight/input registers,
// running the MAC for a fixed number of enabled cycles and returning the result.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ACC_W      = DEF_ACC_W,
  parameter int unsigned N_TAPS     = DEF_N_TAPS,
  parameter int unsigned ACC_CYCLES = DEF_ACC_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keep_w,
  input  logic              abort,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] mac_in,
  output logic [N_TAPS-1:0] mac_ld_tap,
  output logic              mac_ld,
  output logic              mac_clken,
  input  logic [ACC_W-1:0]  mac_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);

  localparam int unsigned TAP_W = cnt_w(N_TAPS);
  localparam int unsigned CYC_W = cnt_w(ACC_CYCLES);

  state_e              state_q;
  state_e              state_d;
  logic                hs;
  logic                tap_load;
  logic                tap_dec;
  logic                cyc_load;
  logic                cyc_dec;
  logic                cap;
  logic [TAP_W-1:0]    tap_cnt;
  logic [TAP_W-1:0]    tap_idx;
  logic                tap_zero;
  logic [CYC_W-1:0]    cyc_cnt;
  logic                cyc_zero;
  logic                cyc_cnt_unused;
  logic [N_TAPS-1:0]   tap_stb_d;
  logic                ld_d;
  logic [DATA_W-1:0]   mac_in_d;

  // Tap counter holds remaining weights; index counts up from tap 0.
  mac_seq_cnt #(.W(TAP_W)) u_tap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tap_load),
    .dec      (tap_dec),
    .load_val (TAP_W'(N_TAPS - 1)),
    .cnt      (tap_cnt),
    .zero_c   (tap_zero)
  );

  mac_seq_cnt #(.W(CYC_W)) u_cyc_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cyc_load),
    .dec      (cyc_dec),
    .load_val (CYC_W'(ACC_CYCLES - 1)),
    .cnt      (cyc_cnt),
    .zero_c   (cyc_zero)
  );

  assign cyc_cnt_unused = ^cyc_cnt;
  assign tap_idx        = TAP_W'(N_TAPS - 1) - tap_cnt;
  assign hs             = in_valid & in_ready;

  // Next-state and next-strobe logic; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    tap_load  = 1'b0;
    tap_dec   = 1'b0;
    cyc_load  = 1'b0;
    cyc_dec   = 1'b0;
    cap       = 1'b0;
    tap_stb_d = '0;
    ld_d      = 1'b0;
    mac_in_d  = mac_in;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tap_load = 1'b1;
          state_d  = keep_w ? LOAD_X : LOAD_W;
        end
      end
      LOAD_W: begin
        if (hs) begin
          mac_in_d  = in_data;
          tap_stb_d = N_TAPS'(1) << tap_idx;
          tap_dec   = 1'b1;
          if (tap_zero) state_d = LOAD_X;
        end
      end
      LOAD_X: begin
        if (hs) begin
          mac_in_d = in_data;
          ld_d     = 1'b1;
          cyc_load = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cyc_zero) state_d = CAPTURE;
        else          cyc_dec = 1'b1;
      end
      CAPTURE: begin
        cap     = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      tap_load  = 1'b0;
      tap_dec   = 1'b0;
      cyc_load  = 1'b0;
      cyc_dec   = 1'b0;
      cap       = 1'b0;
      tap_stb_d = '0;
      ld_d      = 1'b0;
      mac_in_d  = mac_in;
    end
  end

  // Outputs are registered from the next state so they align with the state they describe.
  // mac_ld coincides with the first enabled MAC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      mac_in     <= '0;
      mac_ld_tap <= '0;
      mac_ld     <= 1'b0;
      mac_clken  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      in_ready   <= (state_d == LOAD_W) || (state_d == LOAD_X);
      mac_in     <= mac_in_d;
      mac_ld_tap <= tap_stb_d;
      mac_ld     <= ld_d;
      mac_clken  <= (state_d == RUN);
      res_valid  <= (state_d == HOLD);
      if (cap) res_data <= mac_out;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: per-cycle compare against a phase-level model
// plus hand-computed literal checks on strobe order, latency and result.
module tb_mac_seq_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int NT = 4;
  localparam int AC = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          keep_w;
  logic          abort;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] mac_in;
  logic [NT-1:0] mac_ld_tap;
  logic          mac_ld;
  logic          mac_clken;
  logic [AW-1:0] mac_out;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;

  mac_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .keep_w     (keep_w),
    .abort      (abort),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mac_in     (mac_in),
    .mac_ld_tap (mac_ld_tap),
    .mac_ld     (mac_ld),
    .mac_clken  (mac_clken),
    .mac_out    (mac_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0;
  bit chk_en = 1'b0;

  logic [11:0]   tap_log[$];
  logic [DW-1:0] ld_log[$];
  int            clken_cnt = 0;
  logic [DW-1:0] tx[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic note_timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s t=%0t timed out", nm, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Phase-level model: 0 idle, 1 weights, 2 input, 3 run, 4 capture, 5 hold.
  int            ph = 0;
  int            taps_done = 0;
  int            run_left = 0;
  logic          m_hs;
  logic [DW-1:0] e_mac_in = '0;
  logic [NT-1:0] e_tap = '0;
  logic          e_ld = 1'b0;
  logic [AW-1:0] e_res_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = 0; taps_done = 0; run_left = 0;
      e_mac_in = '0; e_tap = '0; e_ld = 1'b0; e_res_data = '0;
    end else begin
      m_hs  = in_valid && (ph == 1 || ph == 2);
      e_tap = '0;
      e_ld  = 1'b0;
      if (abort) ph = 0;
      else begin
        case (ph)
          0: if (start) begin ph = keep_w ? 2 : 1; taps_done = 0; end
          1: if (m_hs) begin
               e_mac_in = in_data;
               e_tap = NT'(1 << taps_done);
               taps_done++;
               if (taps_done == NT) ph = 2;
             end
          2: if (m_hs) begin e_mac_in = in_data; e_ld = 1'b1; ph = 3; run_left = AC; end
          3: begin run_left--; if (run_left == 0) ph = 4; end
          4: begin e_res_data = mac_out; ph = 5; end
          5: if (res_ready) ph = 0;
          default: ph = 0;
        endcase
      end
    end
  end

  // Single compare process, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      32'(busy),       32'(ph != 0));
      chk("in_ready",  32'(in_ready),   32'(ph == 1 || ph == 2));
      chk("mac_in",    32'(mac_in),     32'(e_mac_in));
      chk("ld_tap",    32'(mac_ld_tap), 32'(e_tap));
      chk("mac_ld",    32'(mac_ld),     32'(e_ld));
      chk("clken",     32'(mac_clken),  32'(ph == 3));
      chk("res_valid", 32'(res_valid),  32'(ph == 5));
      chk("res_data",  32'(res_data),   32'(e_res_data));
    end
  end

  // Observation log of what the DUT actually strobed.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      if (mac_ld_tap != '0) tap_log.push_back({mac_ld_tap, mac_in});
      if (mac_ld) ld_log.push_back(mac_in);
      if (mac_clken) clken_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tap_log.delete();
    ld_log.delete();
    clken_cnt = 0;
  endtask

  task automatic start_job(input logic kw);
    start = 1'b1;
    keep_w = kw;
    tick();
    t_start = cyc;
    start = 1'b0;
    keep_w = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int gap);
    bit ok;
    bit h;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      repeat (gap) tick();
      in_data = tx[i];
      in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        h = in_ready;
        tick();
        if (h) begin ok = 1'b1; break; end
      end
      if (!ok) note_timeout("handshake");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_rv();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (res_valid) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) note_timeout("res_valid");
  endtask

  logic [11:0] exp_taps[4];
  logic [11:0] exp_taps6[4];

  initial begin
    exp_taps  = '{12'h101, 12'h202, 12'h403, 12'h804};
    exp_taps6 = '{12'h111, 12'h222, 12'h433, 12'h844};
    start = 1'b0; keep_w = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; res_ready = 1'b0; mac_out = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_mac_in", 32'(mac_in), 32'd0);

    // Async reset in the middle of RUN.
    mac_out = 16'h0bad;
    tx[0] = 8'h3c;
    start_job(1'b1);
    send_bytes(1, 0);
    tick();
    chk("t1_clken_before", 32'(mac_clken), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t1_clken_async", 32'(mac_clken), 32'd0);
    chk("t1_busy_async", 32'(busy), 32'd0);
    chk("t1_rv_async", 32'(res_valid), 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Full job with weight load.
    clear_logs();
    mac_out = 16'h1234;
    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03; tx[3] = 8'h04; tx[4] = 8'h05;
    start_job(1'b0);
    send_bytes(5, 0);
    wait_rv();
    chk("t2_latency", 32'(cyc - t_start), 32'd10);
    chk("t2_res_data", 32'(res_data), 32'h1234);
    chk("t2_ntaps", 32'(tap_log.size()), 32'd4);
    for (int i = 0; i < tap_log.size() && i < 4; i++) chk("t2_tap", 32'(tap_log[i]), 32'(exp_taps[i]));
    chk("t2_nld", 32'(ld_log.size()), 32'd1);
    if (ld_log.size() > 0) chk("t2_ld_data", 32'(ld_log[0]), 32'h05);
    chk("t2_clken_cnt", 32'(clken_cnt), 32'd4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t2_rv_drop", 32'(res_valid), 32'd0);

    // keep_w=1 with stalled input stream.
    clear_logs();
    mac_out = 16'h00aa;
    tx[0] = 8'h7f;
    start_job(1'b1);
    send_bytes(1, 2);
    wait_rv();
    chk("t3_latency", 32'(cyc - t_start), 32'd8);
    chk("t3_ntaps", 32'(tap_log.size()), 32'd0);
    chk("t3_nld", 32'(ld_log.size()), 32'd1);
    if (ld_log.size() > 0) chk("t3_ld_data", 32'(ld_log[0]), 32'h7f);
    chk("t3_clken_cnt", 32'(clken_cnt), 32'd4);

    // Result held under back-pressure; start ignored.
    mac_out = 16'hdead;
    for (int k = 0; k < 10; k++) begin
      start = (k % 3 == 0);
      tick();
      chk("t4_rv", 32'(res_valid), 32'd1);
      chk("t4_data", 32'(res_data), 32'h00aa);
      chk("t4_busy", 32'(busy), 32'd1);
    end
    start = 1'b1;
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    res_ready = 1'b0;
    chk("t4_release", 32'(busy), 32'd0);
    tick();
    chk("t4_start_dropped", 32'(busy), 32'd0);

    // Abort on the third weight handshake.
    clear_logs();
    mac_out = '0;
    tx[0] = 8'ha1; tx[1] = 8'ha2;
    start_job(1'b0);
    send_bytes(2, 0);
    in_data = 8'ha3;
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_tap", 32'(mac_ld_tap), 32'd0);
    tick();
    chk("t5_ntaps", 32'(tap_log.size()), 32'd2);
    chk("t5_mac_in_hold", 32'(mac_in), 32'ha2);

    // Back-to-back jobs.
    clear_logs();
    mac_out = 16'h5a5a;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44; tx[4] = 8'h55;
    start_job(1'b0);
    send_bytes(5, 0);
    wait_rv();
    chk("t6_res_a", 32'(res_data), 32'h5a5a);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    mac_out = 16'h0f0f;
    tx[0] = 8'h66;
    start_job(1'b1);
    send_bytes(1, 0);
    wait_rv();
    chk("t6_latency_b", 32'(cyc - t_start), 32'd6);
    chk("t6_res_b", 32'(res_data), 32'h0f0f);
    chk("t6_ntaps", 32'(tap_log.size()), 32'd4);
    for (int i = 0; i < tap_log.size() && i < 4; i++) chk("t6_tap", 32'(tap_log[i]), 32'(exp_taps6[i]));
    chk("t6_nld", 32'(ld_log.size()), 32'd2);
    if (ld_log.size() > 1) begin
      chk("t6_ld0", 32'(ld_log[0]), 32'h55);
      chk("t6_ld1", 32'(ld_log[1]), 32'h66);
    end
    chk("t6_clken_cnt", 32'(clken_cnt), 32'd8);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
